// File: rtl/e203_cmt_monitor_pkg.sv
// Shared types and constants for the E203 commit-stream monitor and its IRQ stimulus channels.
// No logic here: state encodings, LFSR polynomial/seed and the LFSR step function.
package e203_cmt_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_START,
        RUN,
        DRAIN,
        DONE
    } mon_state_e;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ASSERT
    } chan_state_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/e203_cmt_monitor_if.sv
// Commit/dispatch observation bus into the monitor plus its IRQ, counter and verdict outputs.
// master = SoC/bench side driving the commit stream, slave = the monitor.
interface e203_cmt_monitor_if #(
    parameter int PC_W = 32,
    parameter int XLEN = 32
);
    logic            cmt_valid;
    logic [PC_W-1:0] cmt_pc;
    logic            exu_i_valid;
    logic            exu_i_ready;
    logic [XLEN-1:0] x3;
    logic            irq_en;

    logic            ext_irq;
    logic            sft_irq;
    logic            tmr_irq;
    logic [31:0]     cycle_cnt;
    logic [31:0]     instr_cnt;
    logic [31:0]     end_cycle;
    logic [31:0]     tohost_cnt;
    logic            done;
    logic            pass;
    logic            timeout;

    modport master (
        output cmt_valid, cmt_pc, exu_i_valid, exu_i_ready, x3, irq_en,
        input  ext_irq, sft_irq, tmr_irq, cycle_cnt, instr_cnt, end_cycle,
               tohost_cnt, done, pass, timeout
    );

    modport slave (
        input  cmt_valid, cmt_pc, exu_i_valid, exu_i_ready, x3, irq_en,
        output ext_irq, sft_irq, tmr_irq, cycle_cnt, instr_cnt, end_cycle,
               tohost_cnt, done, pass, timeout
    );

endinterface

// File: rtl/e203_irq_stim_chan.sv
// One IRQ stimulus channel: random delay (slice+1 cycles), then hold irq until its handler PC commits.
// irq is a registered state decode; no backpressure, kill forces IDLE on the next edge.
module e203_irq_stim_chan
    import e203_cmt_mon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] slice,
    input  logic       hit,
    input  logic       kill,
    output logic       irq
);

    chan_state_e st_q, st_d;
    logic [10:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_d  = DELAY;
                    cnt_d = {1'b0, slice} + 11'd1;
                end
            end
            DELAY: begin
                // start also covers "left RUN" and "irq_en dropped"
                if (!start) begin
                    st_d = IDLE;
                end else if (cnt_q == 11'd1) begin
                    st_d = ASSERT;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            ASSERT: begin
                if (hit) begin
                    if (start) begin
                        st_d  = DELAY;
                        cnt_d = {1'b0, slice} + 11'd1;
                    end else begin
                        st_d = IDLE;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
        if (kill) begin
            st_d = IDLE;
        end
    end

    assign irq = (st_q == ASSERT);

endmodule

// File: rtl/e203_cmt_monitor.sv
// Commit-stream monitor: end-of-test detection, pass/fail verdict, perf counters and random IRQ stimulus.
// Observes only (never stalls the core); counters/flags update one cycle after the observed event.
module e203_cmt_monitor
    import e203_cmt_mon_pkg::*;
#(
    parameter int              PC_W          = 32,
    parameter int              XLEN          = 32,
    parameter logic [PC_W-1:0] PC_START      = 32'h8000015C,
    parameter logic [PC_W-1:0] PC_TOHOST     = 32'h80000086,
    parameter logic [PC_W-1:0] PC_EXT_RET    = 32'h800000A6,
    parameter logic [PC_W-1:0] PC_SFT_RET    = 32'h800000BE,
    parameter logic [PC_W-1:0] PC_TMR_RET    = 32'h800000D6,
    parameter int              TOHOST_TARGET = 8,
    parameter int              IRQ_STOP      = 32,
    parameter int              TIMEOUT_CYC   = 10000000,
    parameter logic [15:0]     LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    e203_cmt_monitor_if.slave mon
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT_SEED : LFSR_SEED;

    mon_state_e  state_q, state_d;
    logic [31:0] cycle_q, instr_q, end_q, tohost_q;
    logic        done_q, pass_q, timeout_q;
    logic [15:0] lfsr_q;
    logic        finish;

    logic hit_start, hit_tohost, hit_ext, hit_sft, hit_tmr;
    logic dispatch, timeout_hit, first_tohost;
    logic chan_start, chan_kill;
    logic ext_raw, sft_raw, tmr_raw;

    assign hit_start  = mon.cmt_valid && (mon.cmt_pc == PC_START);
    assign hit_tohost = mon.cmt_valid && (mon.cmt_pc == PC_TOHOST);
    assign hit_ext    = mon.cmt_valid && (mon.cmt_pc == PC_EXT_RET);
    assign hit_sft    = mon.cmt_valid && (mon.cmt_pc == PC_SFT_RET);
    assign hit_tmr    = mon.cmt_valid && (mon.cmt_pc == PC_TMR_RET);
    assign dispatch   = mon.exu_i_valid && mon.exu_i_ready;

    assign timeout_hit  = (state_q != DONE) && (cycle_q == 32'(TIMEOUT_CYC - 1));
    assign first_tohost = hit_tohost && (state_q != DONE) && (tohost_q == 32'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_START: if (hit_start) state_d = RUN;
            RUN:        if (tohost_q >= 32'(TOHOST_TARGET)) state_d = DRAIN;
            DRAIN:      if (!(ext_raw || sft_raw || tmr_raw)) state_d = DONE;
            default:    state_d = DONE;
        endcase
        if (timeout_hit) begin
            state_d = DONE;
        end
        finish = (state_q != DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_START;
            cycle_q   <= '0;
            instr_q   <= '0;
            end_q     <= '0;
            tohost_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            lfsr_q    <= SEED;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next(lfsr_q);
            // Freeze on the timeout edge too, so cycle_cnt reads TIMEOUT_CYC-1 in DONE
            if ((state_q != DONE) && !timeout_hit) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (dispatch && (tohost_q == 32'd0)) begin
                instr_q <= instr_q + 32'd1;
            end
            if (hit_tohost && (state_q != DONE) && (tohost_q != 32'hFFFF_FFFF)) begin
                tohost_q <= tohost_q + 32'd1;
            end
            if (first_tohost) begin
                end_q <= cycle_q;
            end
            if (finish) begin
                done_q    <= 1'b1;
                timeout_q <= timeout_hit;
                pass_q    <= !timeout_hit && (mon.x3 == XLEN'(1));
            end
        end
    end

    assign chan_start = (state_q == RUN) && mon.irq_en && (tohost_q <= 32'(IRQ_STOP));
    assign chan_kill  = (state_q == DONE);

    e203_irq_stim_chan u_ext (
        .clk   (clk),
        .rst   (rst),
        .start (chan_start),
        .slice (lfsr_q[9:0]),
        .hit   (hit_ext),
        .kill  (chan_kill),
        .irq   (ext_raw)
    );

    e203_irq_stim_chan u_sft (
        .clk   (clk),
        .rst   (rst),
        .start (chan_start),
        .slice (lfsr_q[12:3]),
        .hit   (hit_sft),
        .kill  (chan_kill),
        .irq   (sft_raw)
    );

    e203_irq_stim_chan u_tmr (
        .clk   (clk),
        .rst   (rst),
        .start (chan_start),
        .slice (lfsr_q[15:6]),
        .hit   (hit_tmr),
        .kill  (chan_kill),
        .irq   (tmr_raw)
    );

    // IRQs drop in the same cycle rst is raised, not just after the reset edge
    assign mon.ext_irq    = ext_raw && !rst;
    assign mon.sft_irq    = sft_raw && !rst;
    assign mon.tmr_irq    = tmr_raw && !rst;
    assign mon.cycle_cnt  = cycle_q;
    assign mon.instr_cnt  = instr_q;
    assign mon.end_cycle  = end_q;
    assign mon.tohost_cnt = tohost_q;
    assign mon.done       = done_q;
    assign mon.pass       = pass_q;
    assign mon.timeout    = timeout_q;

endmodule

// File: tb/tb_e203_cmt_monitor.sv
// Directed bench for e203_cmt_monitor: timeout, pass/fail verdicts, IRQ timing/handlers, drain wait, mid-test reset.
module tb_e203_cmt_monitor;

    localparam logic [31:0] PC_START  = 32'h8000015C;
    localparam logic [31:0] PC_TOHOST = 32'h80000086;
    localparam logic [31:0] PC_EXT    = 32'h800000A6;
    localparam logic [31:0] PC_SFT    = 32'h800000BE;
    localparam logic [31:0] PC_TMR    = 32'h800000D6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e203_cmt_monitor_if ifc ();
    e203_cmt_monitor_if ifc_to ();

    e203_cmt_monitor #(.TIMEOUT_CYC(20000)) dut (
        .clk (clk),
        .rst (rst),
        .mon (ifc.slave)
    );

    e203_cmt_monitor #(.TIMEOUT_CYC(100)) dut_to (
        .clk (clk),
        .rst (rst),
        .mon (ifc_to.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int m_instr = 0;
    int m_end   = 0;
    bit m_seen  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.cmt_valid   = 1'b0;
        ifc.cmt_pc      = '0;
        ifc.exu_i_valid = 1'b0;
        ifc.exu_i_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        k = 0;
        m_instr = 0;
        m_end   = 0;
        m_seen  = 1'b0;
    endtask

    // One bench cycle: optional commit, fixed dispatch pattern, model of instr_cnt/end_cycle
    task automatic cyc(input logic v, input logic [31:0] pc);
        ifc.cmt_valid   = v;
        ifc.cmt_pc      = v ? pc : 32'h0;
        ifc.exu_i_valid = 1'b1;
        ifc.exu_i_ready = (k % 3 != 0);
        if (ifc.exu_i_ready && !m_seen) m_instr++;
        if (v && pc == PC_TOHOST && !m_seen) begin
            m_seen = 1'b1;
            m_end  = k;
        end
        step();
        ifc.cmt_valid = 1'b0;
    endtask

    task automatic tohost_burst();
        for (int i = 0; i < 8; i++) begin
            if (i != 0) repeat (9) cyc(1'b0, 32'h0);
            cyc(1'b1, PC_TOHOST);
        end
    endtask

    task automatic verdict_run(input logic [31:0] x3v, input logic exp_pass, input string nm);
        int waited;
        ifc.x3 = x3v;
        ifc.irq_en = 1'b0;
        do_reset();
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        cyc(1'b1, PC_START);
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        tohost_burst();
        waited = 0;
        while (!ifc.done && waited < 6) begin
            cyc(1'b0, 32'h0);
            waited++;
        end
        chk({nm, "_done"}, ifc.done, 1);
        chk({nm, "_done_lat"}, waited, 2);
        chk({nm, "_pass"}, ifc.pass, exp_pass);
        chk({nm, "_timeout"}, ifc.timeout, 0);
        chk({nm, "_tohost"}, ifc.tohost_cnt, 8);
        chk({nm, "_end_cycle"}, ifc.end_cycle, m_end);
        chk({nm, "_instr"}, ifc.instr_cnt, m_instr);
        chk({nm, "_irqs"}, {ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 0);
    endtask

    initial begin
        logic [15:0] l;
        int r_ext, r_sft, r_tmr, e_ext, e_sft, e_tmr, hi;

        ifc.x3 = '0;
        ifc.irq_en = 1'b0;
        ifc_to.cmt_valid   = 1'b0;
        ifc_to.cmt_pc      = '0;
        ifc_to.exu_i_valid = 1'b0;
        ifc_to.exu_i_ready = 1'b0;
        ifc_to.x3          = '0;
        ifc_to.irq_en      = 1'b0;

        // Timeout with no commits at all
        do_reset();
        chk("rst_cycle", ifc.cycle_cnt, 0);
        chk("rst_flags", {ifc.done, ifc.pass, ifc.timeout}, 0);
        repeat (110) cyc(1'b0, 32'h0);
        chk("to_done", ifc_to.done, 1);
        chk("to_timeout", ifc_to.timeout, 1);
        chk("to_pass", ifc_to.pass, 0);
        chk("to_cycle_frozen", ifc_to.cycle_cnt, 99);
        chk("to_irqs", {ifc_to.ext_irq, ifc_to.sft_irq, ifc_to.tmr_irq}, 0);
        chk("main_no_timeout", ifc.done, 0);

        verdict_run(32'd1, 1'b1, "pass");
        verdict_run(32'd5, 1'b0, "fail");

        // IRQ timing, per-channel handlers, DRAIN held by tmr_irq
        ifc.x3 = 32'd1;
        ifc.irq_en = 1'b1;
        do_reset();
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        cyc(1'b1, PC_START);
        l = lfsr_at(3);
        e_ext = 5 + int'(l[9:0]);
        e_sft = 5 + int'(l[12:3]);
        e_tmr = 5 + int'(l[15:6]);
        r_ext = -1;
        r_sft = -1;
        r_tmr = -1;
        while ((r_ext < 0 || r_sft < 0 || r_tmr < 0) && k < 1200) begin
            if (ifc.ext_irq && r_ext < 0) r_ext = k;
            if (ifc.sft_irq && r_sft < 0) r_sft = k;
            if (ifc.tmr_irq && r_tmr < 0) r_tmr = k;
            cyc(1'b0, 32'h0);
        end
        chk("ext_rise", r_ext, e_ext);
        chk("sft_rise", r_sft, e_sft);
        chk("tmr_rise", r_tmr, e_tmr);
        ifc.irq_en = 1'b0;
        cyc(1'b1, PC_EXT);
        chk("ext_handler", {ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 3'b011);
        cyc(1'b1, PC_SFT);
        chk("sft_handler", {ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 3'b001);
        tohost_burst();
        repeat (5) cyc(1'b0, 32'h0);
        chk("drain_hold", {ifc.done, ifc.tmr_irq}, 2'b01);
        chk("drain_tohost", ifc.tohost_cnt, 8);
        cyc(1'b1, PC_TMR);
        chk("tmr_handler", {ifc.done, ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 4'b0000);
        cyc(1'b0, 32'h0);
        chk("drain_exit", {ifc.done, ifc.pass, ifc.timeout}, 3'b110);
        hi = 0;
        repeat (20) begin
            cyc(1'b0, 32'h0);
            if (ifc.ext_irq || ifc.sft_irq || ifc.tmr_irq) hi++;
        end
        chk("quiet_after_done", hi, 0);

        // Reset in the middle of RUN with ext_irq asserted
        ifc.irq_en = 1'b1;
        do_reset();
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        cyc(1'b1, PC_START);
        while (!ifc.ext_irq && k < 1200) cyc(1'b0, 32'h0);
        chk("pre_rst_ext", ifc.ext_irq, 1);
        rst = 1'b1;
        #1;
        chk("rst_irq_now", {ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 0);
        step();
        rst = 1'b0;
        k = 0;
        m_instr = 0;
        m_end   = 0;
        m_seen  = 1'b0;
        chk("mid_rst_cycle", ifc.cycle_cnt, 0);
        chk("mid_rst_instr", ifc.instr_cnt, 0);
        chk("mid_rst_tohost", ifc.tohost_cnt, 0);
        chk("mid_rst_irqs", {ifc.ext_irq, ifc.sft_irq, ifc.tmr_irq}, 0);
        hi = 0;
        repeat (50) begin
            cyc(1'b0, 32'h0);
            if (ifc.ext_irq || ifc.sft_irq || ifc.tmr_irq) hi++;
        end
        chk("wait_start_quiet", hi, 0);
        cyc(1'b1, PC_START);
        l = lfsr_at(51);
        e_ext = 53 + int'(l[9:0]);
        r_ext = -1;
        while (r_ext < 0 && k < 1200) begin
            if (ifc.ext_irq) r_ext = k;
            cyc(1'b0, 32'h0);
        end
        chk("restart_ext_rise", r_ext, e_ext);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_cmt_monitor.md
Name: e203_cmt_monitor

Overview:
- Synthesizable commit-stream monitor and interrupt stimulus generator for E203 SoC simulation; sits directly downstream of the EXU commit stage.
- Consumes the commit valid/PC, the EXU dispatch handshake and the x3 register value.
- Produces end-of-test detection, the pass/fail verdict and performance counters.
- Drives randomized ext/sft/tmr IRQ requests, which are deasserted when the handler's pre-mret PC commits.

Parameters:
- PC_W, 32, commit PC width
- XLEN, 32, register width
- PC_START, 32'h8000015C, PC marking exit from reset_vector code
- PC_TOHOST, 32'h80000086, PC of the tohost write
- PC_EXT_RET / PC_SFT_RET / PC_TMR_RET, 32'h800000A6 / 32'h800000BE / 32'h800000D6, handler pre-mret PCs
- TOHOST_TARGET, 8, tohost commits required to finish
- IRQ_STOP, 32, no new IRQs once tohost_cnt > IRQ_STOP
- TIMEOUT_CYC, 10000000, cycle limit
- LFSR_SEED, 16'hACE1, nonzero LFSR seed; 0 is replaced by 16'hACE1

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmt_valid  in  1  ALU commit valid
- cmt_pc  in  PC_W  ALU commit PC
- exu_i_valid  in  1  EXU dispatch valid
- exu_i_ready  in  1  EXU dispatch ready
- x3  in  XLEN  architectural x3
- irq_en  in  1  enable IRQ stimulus
- ext_irq / sft_irq / tmr_irq  out  1 each  IRQ requests
- cycle_cnt  out  32  cycles since reset
- instr_cnt  out  32  dispatched instructions before first tohost
- end_cycle  out  32  cycle_cnt value at first tohost commit
- tohost_cnt  out  32  tohost commit count
- done / pass / timeout  out  1 each  sticky verdict flags

Behaviour:
- Reset: all outputs 0; FSM enters WAIT_START; LFSR loads the seed; all channels go to IDLE.
- Event definitions:
  - hit(X) = cmt_valid & (cmt_pc == X).
  - dispatch = exu_i_valid & exu_i_ready.
- Main FSM:
  - WAIT_START -> RUN on hit(PC_START).
  - RUN -> DRAIN in the cycle after tohost_cnt becomes TOHOST_TARGET.
  - DRAIN -> DONE when all three IRQs are low. In that cycle: done=1, pass=(x3==1).
  - Any non-DONE state -> DONE when cycle_cnt == TIMEOUT_CYC-1. Sets done=1, timeout=1, pass=0. Timeout takes priority over the DRAIN exit in the same cycle.
  - DONE is absorbing until rst.
- cycle_cnt: +1 every cycle unless in DONE, where it freezes; wraps at 2^32.
- instr_cnt: +1 on dispatch while no tohost commit has been seen yet. The cycle of the first hit(PC_TOHOST) still counts.
- tohost_cnt: +1 on hit(PC_TOHOST) in any state except DONE; saturates at 32'hFFFFFFFF.
- end_cycle: loads cycle_cnt on the first hit(PC_TOHOST) only.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle.
- Slice assignment: ext uses lfsr[9:0], sft uses lfsr[12:3], tmr uses lfsr[15:6].
- IRQ channel FSM (one per IRQ), states IDLE, DELAY, ASSERT:
  - IDLE -> DELAY when FSM==RUN & irq_en & tohost_cnt <= IRQ_STOP. Loads delay = slice+1 (range 1..1024).
  - DELAY: decrement; at 1, go to ASSERT next cycle with irq=1. Return to IDLE (irq stays 0) if FSM leaves RUN or irq_en drops.
  - ASSERT: irq held high until hit(own handler PC), then irq=0 next cycle.
  - After the handler hit, go to DELAY with a new delay if the start condition still holds, otherwise IDLE.
  - ASSERT is never abandoned because of irq_en, DRAIN or stop. Only rst or timeout (DONE) clears it.
- Simultaneous events:
  - A handler hit for one channel does not affect the other channels.
  - hit(PC_TOHOST) and the timeout in the same cycle: the counter still updates, and timeout wins.
- Reset mid-test: everything returns to reset values the next cycle, and all IRQs drop immediately.

Decomposition:
- Package e203_cmt_mon_pkg holds:
  - main FSM state typedef {WAIT_START, RUN, DRAIN, DONE}
  - channel state typedef {IDLE, DELAY, ASSERT}
  - LFSR polynomial and default-seed constants
- One sub-module, e203_irq_stim_chan, instantiated three times. Inputs: start condition, LFSR slice, handler hit, kill. Output: irq.

Test Plan:
- Reset then idle, no commits, TIMEOUT_CYC=100 -> at cycle 99: done=1, timeout=1, pass=0; cycle_cnt frozen at 99; all IRQs 0.
- Commit PC_START, then 8 tohost commits 10 cycles apart, irq_en=0, x3=1 -> end_cycle equals the first tohost cycle; tohost_cnt=8; done=1, pass=1 within 2 cycles of the 8th commit.
- Same sequence with x3=5 -> done=1, pass=0, timeout=0.
- irq_en=1, seed 16'hACE1 -> ext_irq rises after lfsr[9:0]+1 cycles and falls the cycle after hit(32'h800000A6). sft and tmr stay high until their own PCs commit.
- tohost_cnt reaches 8 while tmr_irq is high -> FSM waits in DRAIN; DONE follows one cycle after tmr_irq falls; no new IRQs are issued.
- Assert rst mid-RUN with ext_irq high -> next cycle all counters 0, IRQs 0, FSM in WAIT_START; a later PC_START commit restarts normally.
